mh_drive_sequencer: RTL and testbench

Time-shares a bank of MH power-PNP inverter drivers among magnet/lamp requesters (typewriter, punch and indicator magnets) so that at most one driver is active at a time. Each granted request produces a fixed-width drive pulse followed by a mandatory recovery gap, which limits peak -12V supply load. The block sits between control logic and the MH card `k` inputs. Its active-low drive outputs map directly onto an MH input, where 0 switches the open-collector output on.

---
 rtl/mh_drive_sequencer.sv | 146 ++++++++++++++
 tb/tb_mh_drive_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mh_drive_sequencer.sv
// mh_drive_sequencer
// Time-shares a bank of MH power-PNP inverter drivers among several
// magnet/lamp requesters. At most one driver is on at any time. Each grant
// produces a fixed-width drive pulse followed by an all-off recovery gap.
// The gap limits peak load on the -12V supply.
//
// Build option:
//   MH_SEQ_ROUND_ROBIN_EN  defined   -> round-robin arbitration; the search
//                                       starts after the last granted channel
//                                       and wraps from N_REQ-1 to 0.
//                          undefined -> fixed priority; the lowest index wins.
//
// drv_n is active low and maps directly onto an MH `k` input:
// 0 switches the open-collector output on.

module mh_drive_sequencer #(
    parameter int N_REQ          = 4,   // requesters / driver channels, 2..8
    parameter int PULSE_CYCLES   = 20,  // drive pulse length in clocks, >= 1
    parameter int RECOVER_CYCLES = 8    // all-off gap after each pulse, >= 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    output logic [N_REQ-1:0]           drv_n,
    output logic [N_REQ-1:0]           ack,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_idx
);

    localparam int IDX_W = $clog2(N_REQ);

    // The counter only has to hold (length - 1) of the longer phase. It keeps
    // at least one bit so that the 1-cycle configurations stay legal.
    localparam int MAX_CYCLES = (PULSE_CYCLES > RECOVER_CYCLES) ? PULSE_CYCLES : RECOVER_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVER_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               any_req;
    logic [IDX_W-1:0]   sel_idx;

`ifdef MH_SEQ_ROUND_ROBIN_EN
    // Search start for the next round-robin arbitration. It advances only on a grant.
    logic [IDX_W-1:0]   rr_ptr;
`endif

    // Arbiter: choose the channel that a grant from IDLE would serve.
    // An X/Z on a req bit fails the if-test, so it counts as no request.
    always_comb begin : arbiter
`ifdef MH_SEQ_ROUND_ROBIN_EN
        int  cand;
        logic found;
`endif
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        any_req = |req;
        sel_idx = '0;
`ifdef MH_SEQ_ROUND_ROBIN_EN
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!found && req[cand]) begin
                found   = 1'b1;
                sel_idx = IDX_W'(cand);
            end
        end
`else
        // Scan from the top down so that the lowest active index is the last assignment.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
`endif
    end

    // Sequencer FSM. All outputs are registered, so req has no combinational path to drv_n or ack.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments. Every register then sees pre-edge values.
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            drv_n     <= '1;
            ack       <= '0;
            busy      <= 1'b0;
            grant_idx <= '0;
`ifdef MH_SEQ_ROUND_ROBIN_EN
            rr_ptr    <= '0;
`endif
        end else begin
            // ack is a single-cycle strobe, so it clears on every edge unless it is set below.
            ack <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= DRIVE;
                        cnt       <= PULSE_LOAD;
                        grant_idx <= sel_idx;
                        drv_n     <= ~(N_REQ'(1) << sel_idx);
                        busy      <= 1'b1;
`ifdef MH_SEQ_ROUND_ROBIN_EN
                        rr_ptr    <= (sel_idx == IDX_W'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;
`endif
                    end
                end
                DRIVE: begin
                    // A pulse always runs to completion, even if req drops.
                    if (cnt == '0) begin
                        state <= RECOVER;
                        cnt   <= RECOVER_LOAD;
                        drv_n <= '1;
                        ack   <= N_REQ'(1) << grant_idx;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RECOVER: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    drv_n <= '1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mh_drive_sequencer.sv
// tb_mh_drive_sequencer
// Self-checking bench for mh_drive_sequencer. It runs a default instance
// (4 channels, 20/8) and an edge instance (2 channels, 1/1) side by side.
// A reference model describes each grant as a pulse start cycle plus a
// channel. All expected outputs come from that start time with plain
// arithmetic. The round-robin expectations follow MH_SEQ_ROUND_ROBIN_EN
// when that macro is defined.

module tb_mh_drive_sequencer;

    logic       clk;
    logic       reset;
    logic [3:0] req4;
    logic [3:0] drv4;
    logic [3:0] ack4;
    logic       busy4;
    logic [1:0] gidx4;
    logic [1:0] req2;
    logic [1:0] drv2;
    logic [1:0] ack2;
    logic       busy2;
    logic [0:0] gidx2;

    mh_drive_sequencer u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .req       (req4),
        .drv_n     (drv4),
        .ack       (ack4),
        .busy      (busy4),
        .grant_idx (gidx4)
    );

    mh_drive_sequencer #(
        .N_REQ          (2),
        .PULSE_CYCLES   (1),
        .RECOVER_CYCLES (1)
    ) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .req       (req2),
        .drv_n     (drv2),
        .ack       (ack2),
        .busy      (busy2),
        .grant_idx (gidx2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MH_SEQ_ROUND_ROBIN_EN
    localparam int EXP_P3_4 [5] = '{0, 1, 2, 3, 0};
    localparam int EXP_P3_2 [4] = '{0, 1, 0, 1};
    localparam int EXP_P4   [3] = '{1, 3, 3};
`else
    localparam int EXP_P3_4 [5] = '{0, 0, 0, 0, 0};
    localparam int EXP_P3_2 [4] = '{0, 0, 0, 0};
    localparam int EXP_P4   [3] = '{1, 1, 3};
`endif

    // Model: a grant is the cycle in which its pulse starts plus the channel.
    typedef struct packed {
        int start;  // first drive cycle, -1 when no grant is outstanding
        int g;      // granted channel
        int gidx;   // reported grant index
        int ptr;    // round-robin search start
    } mdl_t;

    mdl_t m4, m2;
    int   cyc;
    int   n_vec, n_err;
    int   drv_cnt4, ack_cnt4;
    logic [3:0] ack_or4, prev_drv4;
    logic [1:0] prev_drv2;
    int   st4_cyc[$], st4_idx[$], st2_cyc[$], st2_idx[$];

    function automatic mdl_t m_init();
        mdl_t m;
        m.start = -1; m.g = 0; m.gidx = 0; m.ptr = 0;
        return m;
    endfunction

    function automatic logic m_busy(mdl_t m, int c, int p, int r);
        return (m.start >= 0) && (c < m.start + p + r);
    endfunction

    function automatic logic [7:0] m_drv(mdl_t m, int c, int p);
        logic [7:0] v;
        v = 8'hFF;
        if (m.start >= 0 && c >= m.start && c < m.start + p) v[m.g] = 1'b0;
        return v;
    endfunction

    function automatic logic [7:0] m_ack(mdl_t m, int c, int p);
        logic [7:0] v;
        v = 8'h00;
        if (m.start >= 0 && c == m.start + p) v[m.g] = 1'b1;
        return v;
    endfunction

    // Requests in cycle c are only looked at if the block is idle in that cycle.
    function automatic mdl_t m_arb(mdl_t m, int c, logic [7:0] rq, int n, int p, int r);
        int g;
        g = -1;
        if (m_busy(m, c, p, r) || rq == 8'h00) return m;
`ifdef MH_SEQ_ROUND_ROBIN_EN
        for (int k = 0; k < n; k++)
            if (g < 0 && rq[(m.ptr + k) % n]) g = (m.ptr + k) % n;
        m.ptr = (g + 1) % n;
`else
        for (int k = 0; k < n; k++)
            if (g < 0 && rq[k]) g = k;
`endif
        m.start = c + 1;
        m.g     = g;
        m.gidx  = g;
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs, advance the model and the clock, then check the new cycle.
    task automatic step(input logic [3:0] r4, input logic [1:0] r2, input logic rs);
        req4  = r4;
        req2  = r2;
        reset = rs;
        if (rs) begin
            m4 = m_init();
            m2 = m_init();
        end else begin
            m4 = m_arb(m4, cyc, {4'h0, r4}, 4, 20, 8);
            m2 = m_arb(m2, cyc, {6'h0, r2}, 2, 1, 1);
        end
        @(posedge clk);
        #1;
        cyc++;
        check("drv4",    {4'hF, drv4},  m_drv(m4, cyc, 20));
        check("ack4",    {4'h0, ack4},  m_ack(m4, cyc, 20));
        check("busy4",   busy4,         m_busy(m4, cyc, 20, 8));
        check("gidx4",   gidx4,         m4.gidx);
        check("onehot4", ($countones(~drv4) <= 1), 1);
        check("drv2",    {6'h3F, drv2}, m_drv(m2, cyc, 1));
        check("ack2",    {6'h00, ack2}, m_ack(m2, cyc, 1));
        check("busy2",   busy2,         m_busy(m2, cyc, 1, 1));
        check("gidx2",   gidx2,         m2.gidx);
        check("onehot2", ($countones(~drv2) <= 1), 1);
        if (drv4 != 4'hF) drv_cnt4++;
        if (ack4 != 4'h0) ack_cnt4++;
        ack_or4 |= ack4;
        if (drv4 != 4'hF && prev_drv4 == 4'hF) begin
            st4_cyc.push_back(cyc);
            for (int i = 0; i < 4; i++) if (!drv4[i]) st4_idx.push_back(i);
        end
        if (drv2 != 2'b11 && prev_drv2 == 2'b11) begin
            st2_cyc.push_back(cyc);
            for (int i = 0; i < 2; i++) if (!drv2[i]) st2_idx.push_back(i);
        end
        prev_drv4 = drv4;
        prev_drv2 = drv2;
    endtask

    task automatic clear_obs();
        drv_cnt4 = 0; ack_cnt4 = 0; ack_or4 = '0;
        st4_cyc.delete(); st4_idx.delete(); st2_cyc.delete(); st2_idx.delete();
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    initial begin
        logic [3:0] r4;
        logic [1:0] r2;
        logic       seen;
        n_vec = 0; n_err = 0; cyc = 0;
        m4 = m_init(); m2 = m_init();
        prev_drv4 = 4'hF; prev_drv2 = 2'b11;
        req4 = '0; req2 = '0; reset = 1'b1;
        clear_obs();

        // Reset state.
        step(4'h0, 2'b00, 1'b1);
        step(4'h0, 2'b00, 1'b1);
        check("rst_drv",  drv4, 4'hF);
        check("rst_busy", busy4, 0);

        // A single request held for one edge.
        step(4'h0, 2'b00, 1'b0);
        clear_obs();
        step(4'b0001, 2'b00, 1'b0);
        for (int i = 0; i < 31; i++) step(4'h0, 2'b00, 1'b0);
        check("single_drv_cycles", drv_cnt4, 20);
        check("single_ack_cycles", ack_cnt4, 1);
        check("single_ack_chan",   ack_or4, 4'b0001);
        check("single_idle",       busy4, 0);

        // All requests held continuously, starting from reset.
        step(4'h0, 2'b00, 1'b1);
        clear_obs();
        for (int i = 0; i < 150; i++) step(4'b1111, 2'b11, 1'b0);
        for (int i = 0; i < 5; i++) check("p3_grant4", qget(st4_idx, i), EXP_P3_4[i]);
        for (int i = 1; i < 5; i++) check("p3_space4", qget(st4_cyc, i) - qget(st4_cyc, i - 1), 29);
        for (int i = 0; i < 4; i++) check("p3_grant2", qget(st2_idx, i), EXP_P3_2[i]);
        for (int i = 1; i < 4; i++) check("p3_space2", qget(st2_cyc, i) - qget(st2_cyc, i - 1), 3);
        for (int i = 0; i < 35; i++) step(4'h0, 2'b00, 1'b0);

        // req = 1010 held; req[1] drops after the second ack.
        step(4'h0, 2'b00, 1'b1);
        step(4'h0, 2'b00, 1'b0);
        clear_obs();
        for (int i = 0; i < 31; i++) step(4'b1010, 2'b00, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step(4'b1010, 2'b00, 1'b0);
            seen = (ack4 != 4'h0);
        end
        check("p4_ack_wait", seen, 1);
        for (int i = 0; i < 100 && st4_idx.size() < 3; i++) step(4'b1000, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) check("p4_grant", qget(st4_idx, i), EXP_P4[i]);
        for (int i = 0; i < 35; i++) step(4'h0, 2'b00, 1'b0);

        // Request dropped after one cycle: the pulse still completes, followed by a single ack.
        clear_obs();
        step(4'b0100, 2'b00, 1'b0);
        for (int i = 0; i < 40; i++) step(4'h0, 2'b00, 1'b0);
        check("drop_drv_cycles", drv_cnt4, 20);
        check("drop_ack_chan",   ack_or4, 4'b0100);
        check("drop_pulses",     st4_idx.size(), 1);

        // Reset asserted on drive cycle 5.
        step(4'b0010, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) step(4'h0, 2'b00, 1'b0);
        check("mid_in_drive", drv4, 4'b1101);
        step(4'h0, 2'b00, 1'b1);
        check("mid_drv_off", drv4, 4'hF);
        check("mid_gidx",    gidx4, 0);
        clear_obs();
        for (int i = 0; i < 30; i++) step(4'h0, 2'b00, 1'b0);
        check("mid_no_ack", ack_cnt4, 0);
        step(4'b1111, 2'b00, 1'b0);
        step(4'h0, 2'b00, 1'b0);
        check("mid_ptr_restored", qget(st4_idx, 0), 0);
        for (int i = 0; i < 35; i++) step(4'h0, 2'b00, 1'b0);

        // Randomized traffic with occasional resets.
        r4 = '0; r2 = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) r4 = 4'($urandom);
            if ($urandom_range(0, 5) == 0) r2 = 2'($urandom);
            step(r4, r2, ($urandom_range(0, 299) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
